// File: rtl/sweep_acq_controller_if.sv
// Bus between the sweep sequencer and its surroundings: sweep settings and
// Microroc packet strobe in, Microroc control and USB FIFO record stream out.
interface sweep_acq_controller_if;
    logic        SweepAcqStartStop;
    logic [9:0]  StartDac;
    logic [9:0]  EndDac;
    logic [9:0]  DacStep;
    logic [15:0] MaxPackageNumber;
    logic [15:0] ParallelData;
    logic        ParallelData_en;

    logic [9:0]  SweepAcq10BitDac;
    logic        SweepAcqMicrorocSCParameterLoad;
    logic        SweepAcqMicrorocAcqStartStop;
    logic        SweepAcqForceMicrorocAcqReset;
    logic [15:0] SweepAcqData;
    logic        SweepAcqData_en;
    logic        SweepTestUsbStartStop;
    logic        SweepAcqDone;

    // Packet payload is never inspected by the sequencer, so only the source sees it.
    modport master (
        input  SweepAcqStartStop, StartDac, EndDac, DacStep, MaxPackageNumber,
               ParallelData_en,
        output SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad,
               SweepAcqMicrorocAcqStartStop, SweepAcqForceMicrorocAcqReset,
               SweepAcqData, SweepAcqData_en, SweepTestUsbStartStop, SweepAcqDone
    );

    modport slave (
        output SweepAcqStartStop, StartDac, EndDac, DacStep, MaxPackageNumber,
               ParallelData, ParallelData_en,
        input  SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad,
               SweepAcqMicrorocAcqStartStop, SweepAcqForceMicrorocAcqReset,
               SweepAcqData, SweepAcqData_en, SweepTestUsbStartStop, SweepAcqDone
    );
endinterface

// File: rtl/sweep_acq_controller.sv
// SWEEP_ACQ sequencer: steps the 10-bit DAC, runs one gated acquisition per point
// and emits a header, one (DAC, packet count) record per point, and a tail word.
module sweep_acq_controller #(
    parameter logic [15:0] LOAD_WAIT_CYCLES = 16'd2000,
    parameter logic [7:0]  RESET_CYCLES     = 8'd10,
    parameter logic [15:0] STOP_WAIT_CYCLES = 16'd1000,
    parameter logic [31:0] ACQ_TIMEOUT      = 32'd40_000_000,
    parameter logic [15:0] HEADER_WORD      = 16'h5A5A,
    parameter logic [15:0] TAIL_WORD        = 16'hA5A5
) (
    input logic Clk,
    input logic reset_n,
    sweep_acq_controller_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, HEAD, LOAD, LOAD_WAIT, RST, ACQ, STOP_WAIT,
        OUT_DAC, OUT_CNT, NEXT, TAIL, DONE
    } state_t;

    state_t      state, next_state;
    logic [9:0]  dac, end_dac, step;
    logic [15:0] max_pkt, pkt_cnt, wait_cnt;
    logic [31:0] timeout_cnt;
    logic        timeout_flag;
    logic [10:0] next_dac;
    logic        count_hit, timeout_hit, acq_exit, start;

    assign start       = bus.SweepAcqStartStop;
    assign next_dac    = {1'b0, dac} + {1'b0, step};
    assign count_hit   = (pkt_cnt == max_pkt);
    assign timeout_hit = (ACQ_TIMEOUT != 32'd0) && (timeout_cnt == ACQ_TIMEOUT);
    assign acq_exit    = count_hit || timeout_hit;

    assign bus.SweepAcq10BitDac      = dac;
    assign bus.SweepTestUsbStartStop = (state != IDLE);
    assign bus.SweepAcqDone          = (state == DONE);

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            dac          <= '0;
            end_dac      <= '0;
            step         <= '0;
            max_pkt      <= '0;
            pkt_cnt      <= '0;
            wait_cnt     <= '0;
            timeout_cnt  <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (next_state != state) ? 16'd0 : wait_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        dac     <= bus.StartDac;
                        end_dac <= bus.EndDac;
                        step    <= (bus.DacStep == 10'd0) ? 10'd1 : bus.DacStep;
                        max_pkt <= bus.MaxPackageNumber;
                    end
                end
                RST: begin
                    pkt_cnt      <= '0;
                    timeout_cnt  <= '0;
                    timeout_flag <= 1'b0;
                end
                ACQ: begin
                    // A strobe arriving in the exit cycle belongs to no point.
                    if (!acq_exit) begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                        if (bus.ParallelData_en)
                            pkt_cnt <= pkt_cnt + 16'd1;
                    end else begin
                        timeout_flag <= timeout_hit && !count_hit;
                    end
                end
                NEXT: begin
                    if (next_state == LOAD)
                        dac <= next_dac[9:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state                          = state;
        bus.SweepAcqMicrorocSCParameterLoad = 1'b0;
        bus.SweepAcqMicrorocAcqStartStop    = 1'b0;
        bus.SweepAcqForceMicrorocAcqReset   = 1'b0;
        bus.SweepAcqData                    = 16'd0;
        bus.SweepAcqData_en                 = 1'b0;
        case (state)
            IDLE: if (start) next_state = HEAD;
            HEAD: begin
                bus.SweepAcqData    = HEADER_WORD;
                bus.SweepAcqData_en = 1'b1;
                next_state          = (dac > end_dac) ? TAIL : LOAD;
            end
            LOAD: begin
                bus.SweepAcqMicrorocSCParameterLoad = 1'b1;
                next_state                          = LOAD_WAIT;
            end
            LOAD_WAIT: if (wait_cnt == LOAD_WAIT_CYCLES - 16'd1) next_state = RST;
            RST: begin
                bus.SweepAcqForceMicrorocAcqReset = 1'b1;
                if (wait_cnt == {8'd0, RESET_CYCLES} - 16'd1) next_state = ACQ;
            end
            ACQ: begin
                bus.SweepAcqMicrorocAcqStartStop = 1'b1;
                if (acq_exit) next_state = STOP_WAIT;
            end
            STOP_WAIT: if (wait_cnt == STOP_WAIT_CYCLES - 16'd1) next_state = OUT_DAC;
            OUT_DAC: begin
                bus.SweepAcqData    = {timeout_flag, 5'b0, dac};
                bus.SweepAcqData_en = 1'b1;
                next_state          = OUT_CNT;
            end
            OUT_CNT: begin
                bus.SweepAcqData    = pkt_cnt;
                bus.SweepAcqData_en = 1'b1;
                next_state          = NEXT;
            end
            NEXT: begin
                // The 11-bit sum keeps a step past 1023 from wrapping back into range.
                if (next_dac > {1'b0, end_dac} || next_dac[10]) next_state = TAIL;
                else                                            next_state = LOAD;
            end
            TAIL: begin
                bus.SweepAcqData    = TAIL_WORD;
                bus.SweepAcqData_en = 1'b1;
                next_state          = DONE;
            end
            DONE: if (!start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (!start && state != IDLE && state != DONE)
            next_state = IDLE;
    end

endmodule
